// File: rtl/store_unit_if.sv
`default_nettype none
// ============================================================================
// Module      : store_unit_if
// Description : Store-request, memory-write and load-probe bundle shared by
//               the MEM stage (master) and the store buffer (slave).
// Revision    : 1.0 - initial release
// ============================================================================
interface store_unit_if;
    // MEM stage store request
    logic        StoreValid;
    logic        StoreReady;
    logic [31:0] Addr;
    logic [31:0] RtData;
    logic [2:0]  Memfunc;
    // Data-memory write port
    logic        MemReq;
    logic        MemAck;
    logic [31:0] MemAddr;
    logic [31:0] MemWData;
    logic [3:0]  MemBE;
    // Status / hazard probe
    logic        AlignErr;
    logic [31:0] LoadAddr;
    logic        LoadHit;
    logic        Empty;

    modport master (
        output StoreValid, Addr, RtData, Memfunc, MemAck, LoadAddr,
        input  StoreReady, MemReq, MemAddr, MemWData, MemBE, AlignErr,
               LoadHit, Empty
    );

    modport slave (
        input  StoreValid, Addr, RtData, Memfunc, MemAck, LoadAddr,
        output StoreReady, MemReq, MemAddr, MemWData, MemBE, AlignErr,
               LoadHit, Empty
    );
endinterface
`default_nettype wire

// File: rtl/store_unit.sv
`default_nettype none
// ============================================================================
// Module      : store_unit
// Description : Store buffer between the MEM stage and data memory. Formats
//               byte/halfword/word stores into lane-replicated data plus byte
//               enables, drops misaligned stores with a one-cycle error pulse,
//               queues aligned stores in a DEPTH-entry FIFO and flags loads
//               that overlap a buffered word.
// Revision    : 1.0 - initial release
// ============================================================================
module store_unit #(
    parameter int DEPTH = 4
) (
    input  wire logic   clk,
    input  wire logic   rst,
    store_unit_if.slave bus
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    // Access-type encodings (mem_func codes)
    localparam logic [2:0] MF_BS = 3'd0;
    localparam logic [2:0] MF_BU = 3'd1;
    localparam logic [2:0] MF_HS = 3'd2;
    localparam logic [2:0] MF_HU = 3'd3;
    localparam logic [2:0] MF_WD = 3'd4;
    localparam logic [2:0] MF_WL = 3'd5;
    localparam logic [2:0] MF_WR = 3'd6;

    // Entry storage
    logic [29:0]      ent_addr_q [DEPTH];
    logic [29:0]      ent_addr_d [DEPTH];
    logic [31:0]      ent_data_q [DEPTH];
    logic [31:0]      ent_data_d [DEPTH];
    logic [3:0]       ent_be_q   [DEPTH];
    logic [3:0]       ent_be_d   [DEPTH];
    logic [DEPTH-1:0] valid_q;
    logic [DEPTH-1:0] valid_d;

    // Pointers and occupancy
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q,  count_d;

    // Registered head-of-queue presentation
    logic [29:0] head_addr_q, head_addr_d;
    logic [31:0] head_data_q, head_data_d;
    logic [3:0]  head_be_q,   head_be_d;
    logic        align_err_q, align_err_d;

    // Formatting and handshake decode
    logic [31:0]      fmt_data;
    logic [3:0]       fmt_be;
    logic             misaligned;
    logic             store_ready;
    logic             accept;
    logic             push;
    logic             pop;
    logic [DEPTH-1:0] hit_vec;
    logic             unused_ok;

    // Lane replication, byte enables and alignment check for the incoming store
    always_comb begin
        fmt_data   = bus.RtData;
        fmt_be     = 4'b1111;
        misaligned = 1'b0;
        case (bus.Memfunc)
            MF_BS, MF_BU: begin
                fmt_data = {4{bus.RtData[7:0]}};
                fmt_be   = 4'b0001 << bus.Addr[1:0];
            end
            MF_HS, MF_HU: begin
                fmt_data   = {2{bus.RtData[15:0]}};
                fmt_be     = bus.Addr[1] ? 4'b1100 : 4'b0011;
                misaligned = bus.Addr[0];
            end
            MF_WD: begin
                misaligned = (bus.Addr[1:0] != 2'b00);
            end
            MF_WL: fmt_be = 4'b1100;
            MF_WR: fmt_be = 4'b0011;
            default: begin
                fmt_data = bus.RtData;
                fmt_be   = 4'b1111;
            end
        endcase
    end

    // Handshake, FIFO next state and next head-of-queue selection
    always_comb begin
        store_ready = (count_q < CNT_W'(DEPTH));
        accept      = bus.StoreValid && store_ready;
        push        = accept && !misaligned;
        // An ack with nothing pending is ignored.
        pop         = bus.MemAck && (count_q != '0);

        ent_addr_d = ent_addr_q;
        ent_data_d = ent_data_q;
        ent_be_d   = ent_be_q;
        valid_d    = valid_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;

        // A push never targets the slot being popped: that would need a full
        // buffer, and a full buffer does not accept.
        if (push) begin
            ent_addr_d[wr_ptr_q] = bus.Addr[31:2];
            ent_data_d[wr_ptr_q] = fmt_data;
            ent_be_d[wr_ptr_q]   = fmt_be;
            valid_d[wr_ptr_q]    = 1'b1;
            wr_ptr_d             = wr_ptr_q + 1'b1;
        end
        if (pop) begin
            valid_d[rd_ptr_q] = 1'b0;
            rd_ptr_d          = rd_ptr_q + 1'b1;
        end
        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase

        // Head comes from the post-update storage so a store pushed into an
        // empty (or just-drained) buffer is presented straight away.
        if (count_d == '0) begin
            head_addr_d = '0;
            head_data_d = '0;
            head_be_d   = '0;
        end else begin
            head_addr_d = ent_addr_d[rd_ptr_d];
            head_data_d = ent_data_d[rd_ptr_d];
            head_be_d   = ent_be_d[rd_ptr_d];
        end

        align_err_d = accept && misaligned;
    end

    // State registers with asynchronous clear of every entry and output
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                ent_addr_q[i] <= '0;
                ent_data_q[i] <= '0;
                ent_be_q[i]   <= '0;
            end
            valid_q     <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            head_addr_q <= '0;
            head_data_q <= '0;
            head_be_q   <= '0;
            align_err_q <= 1'b0;
        end else begin
            ent_addr_q  <= ent_addr_d;
            ent_data_q  <= ent_data_d;
            ent_be_q    <= ent_be_d;
            valid_q     <= valid_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            head_addr_q <= head_addr_d;
            head_data_q <= head_data_d;
            head_be_q   <= head_be_d;
            align_err_q <= align_err_d;
        end
    end

    // Per-entry word-address match against the load in MEM
    generate
        for (genvar g = 0; g < DEPTH; g++) begin : g_hit
            assign hit_vec[g] = valid_q[g] && (ent_addr_q[g] == bus.LoadAddr[31:2]);
        end
    endgenerate

    // Byte offset of the load address does not matter for word overlap.
    assign unused_ok = ^bus.LoadAddr[1:0];

    assign bus.StoreReady = store_ready;
    assign bus.MemReq     = (count_q != '0);
    assign bus.Empty      = (count_q == '0);
    assign bus.MemAddr    = {head_addr_q, 2'b00};
    assign bus.MemWData   = head_data_q;
    assign bus.MemBE      = head_be_q;
    assign bus.AlignErr   = align_err_q;
    assign bus.LoadHit    = |hit_vec;

endmodule
`default_nettype wire

// File: doc/store_unit.md
STORE_UNIT -- requirements
Module: store_unit

Interface
REQ-001 The block SHALL take parameter DEPTH, default 4, as the number of store-buffer entries (power of 2, minimum 2).
REQ-002 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-003 rst  input  1  reset; asynchronous and active-high.
REQ-004 StoreValid  input  1  the MEM stage presents a store request this cycle.
REQ-005 StoreReady  output  1  the buffer can accept a request this cycle.
REQ-006 Addr  input  32  store byte address.
REQ-007 RtData  input  32  store source register value.
REQ-008 Memfunc  input  3  access type, encoded with the mem_func.sv macros (BS, BU, HS, HU, WD, WL, WR).
REQ-009 MemReq  output  1  a write request to data memory is pending.
REQ-010 MemAck  input  1  data memory accepts the pending write this cycle.
REQ-011 MemAddr  output  32  word-aligned write address; bits [1:0] SHALL be 0.
REQ-012 MemWData  output  32  formatted write data.
REQ-013 MemBE  output  4  byte enables; bit i enables byte lane [8i+7:8i].
REQ-014 AlignErr  output  1  registered one-cycle pulse flagging a dropped misaligned store.
REQ-015 LoadAddr  input  32  address of the load currently in MEM.
REQ-016 LoadHit  output  1  a buffered store overlaps the word at LoadAddr.
REQ-017 Empty  output  1  no buffered stores.

Function
REQ-018 A request SHALL be accepted on a rising edge when StoreValid=1 and StoreReady=1.
REQ-019 StoreReady SHALL equal (count < DEPTH), with no same-cycle bypass: a full buffer SHALL not accept a push even while MemAck pops an entry.
REQ-020 Formatting for BS and BU SHALL be: data {4{RtData[7:0]}}; BE = 4'b0001 << Addr[1:0].
REQ-021 Formatting for HS and HU SHALL be: data {2{RtData[15:0]}}; BE = Addr[1] ? 4'b1100 : 4'b0011.
REQ-022 Formatting for WD SHALL be: data RtData; BE 4'b1111.
REQ-023 Formatting for WL SHALL be: data RtData; BE 4'b1100.
REQ-024 Formatting for WR SHALL be: data RtData; BE 4'b0011.
REQ-025 Any other Memfunc code SHALL be formatted as WD.
REQ-026 A halfword access with Addr[0]=1, or a WD access with Addr[1:0]!=0, SHALL be misaligned.
REQ-027 A misaligned request SHALL complete the handshake, SHALL NOT be written to the buffer, and SHALL drive AlignErr=1 for exactly the cycle after acceptance.
REQ-028 An aligned accepted request SHALL be stored as {Addr[31:2], data, BE} at the tail of the FIFO, and the count SHALL increment.
REQ-029 MemReq SHALL equal !Empty.
REQ-030 MemAddr, MemWData and MemBE SHALL present the head entry, registered, and SHALL remain stable while MemReq=1 and MemAck=0.
REQ-031 MemAck=1 while MemReq=1 SHALL pop the head on that edge; MemAck while MemReq=0 SHALL be ignored.
REQ-032 Latency: a store accepted at edge N into an empty buffer SHALL raise MemReq after edge N.
REQ-033 A simultaneous push and pop when count is between 1 and DEPTH-1 SHALL leave the count unchanged, preserving FIFO order.
REQ-034 Read and write pointers SHALL wrap modulo DEPTH.
REQ-035 LoadHit SHALL be combinational: 1 if any valid entry has word address == LoadAddr[31:2], ignoring byte enables.
REQ-036 Empty SHALL equal (count == 0).

Reset
REQ-037 When rst=1, the block SHALL immediately clear all buffered entries, including mid-transfer, and SHALL set: count=0, pointers=0, MemReq=0, Empty=1, StoreReady=1, AlignErr=0, MemAddr=0, MemWData=0, MemBE=0.
REQ-038 A MemAck arriving after reset SHALL have no effect.
REQ-039 The first request after reset de-assertion SHALL be accepted on the next rising edge.

Verification
REQ-040 SB, Addr=0x00001003, RtData=0x000000AB -> MemReq next cycle; MemAddr 0x00001000; MemWData 0xABABABAB; MemBE 4'b1000.
REQ-041 SH, Addr=0x00002002, RtData=0x00001234 -> MemWData 0x12341234; MemBE 4'b1100; then a WR to 0x2000 -> MemBE 4'b0011, queued in order.
REQ-042 SW, Addr=0x00003001 -> AlignErr=1 for one cycle; MemReq stays 0; Empty stays 1.
REQ-043 Push 4 stores with MemAck=0 -> StoreReady=0 after the 4th; a 5th request is held; one MemAck -> StoreReady=1 the next cycle, with first-in data popped first.
REQ-044 Buffered store to 0x4004 with LoadAddr=0x4006 -> LoadHit=1; with LoadAddr=0x4008 -> LoadHit=0.
REQ-045 Assert rst with 3 entries pending and MemReq=1 -> MemReq=0, Empty=1 and StoreReady=1 immediately; no stale entry appears after rst is released.
